// File: rtl/gcd_share_arbiter.sv
// Shares one gcd_top engine between NUM_REQ requesters: round-robin grant, engine sequencing with timeout.
// Define GCD_SHARE_ARBITER_STATS_EN to add the stat_jobs_o / stat_timeouts_o counters.
module gcd_share_arbiter #(
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_operand_a_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_operand_b_i,
  output logic [NUM_REQ-1:0]            resp_valid_o,
  output logic [DATA_WIDTH-1:0]         resp_gcd_o,
  output logic                          resp_err_o,
  output logic                          busy_o,
  output logic [DATA_WIDTH-1:0]         gcd_operand_a_o,
  output logic [DATA_WIDTH-1:0]         gcd_operand_b_o,
  output logic                          gcd_enable_o,
  input  logic [DATA_WIDTH-1:0]         gcd_result_i,
  input  logic                          gcd_done_i
`ifdef GCD_SHARE_ARBITER_STATS_EN
  ,
  output logic [15:0]                   stat_jobs_o,
  output logic [7:0]                    stat_timeouts_o
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [PTR_W-1:0]      owner_q, owner_d;
  logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  grant_found;
  logic [PTR_W-1:0]      grant_idx;
  logic [PTR_W-1:0]      grant_next_ptr;
  logic [DATA_WIDTH-1:0] grant_a;
  logic [DATA_WIDTH-1:0] grant_b;

  // Round-robin search starting at ptr_q, wrapping modulo NUM_REQ.
  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    sum         = '0;
    idx         = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(NUM_REQ)) begin
        sum = sum - (PTR_W+1)'(NUM_REQ);
      end
      idx = sum[PTR_W-1:0];
      if (!grant_found && req_valid_i[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  always_comb begin
    logic [PTR_W:0] nxt;
    nxt = {1'b0, grant_idx} + (PTR_W+1)'(1);
    if (nxt == (PTR_W+1)'(NUM_REQ)) begin
      grant_next_ptr = '0;
    end else begin
      grant_next_ptr = nxt[PTR_W-1:0];
    end
  end

  always_comb begin
    grant_a = '0;
    grant_b = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == PTR_W'(k)) begin
        grant_a = req_operand_a_i[k*DATA_WIDTH +: DATA_WIDTH];
        grant_b = req_operand_b_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Ready is masked during reset so no requester sees an accept that the reset discards.
  always_comb begin
    req_ready_o  = '0;
    resp_valid_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (state_q == IDLE && !reset_i && grant_found && grant_idx == PTR_W'(k)) begin
        req_ready_o[k] = 1'b1;
      end
      if (state_q == RESP && owner_q == PTR_W'(k)) begin
        resp_valid_o[k] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    result_d     = result_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    gcd_enable_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          owner_d = grant_idx;
          ptr_d   = grant_next_ptr;
          op_a_d  = grant_a;
          op_b_d  = grant_b;
          // A zero operand has a trivial gcd, so the engine is skipped entirely.
          if (grant_a == '0 || grant_b == '0) begin
            result_d = grant_a | grant_b;
            err_d    = 1'b0;
            state_d  = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        gcd_enable_o = 1'b1;
        cnt_d        = '0;
        state_d      = WAIT;
      end
      WAIT: begin
        gcd_enable_o = 1'b1;
        if (gcd_done_i) begin
          result_d = gcd_result_i;
          err_d    = 1'b0;
          state_d  = RESP;
        end else if (cnt_q == CNT_LAST) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign gcd_operand_a_o = op_a_q;
  assign gcd_operand_b_o = op_b_q;
  assign resp_gcd_o      = result_q;
  assign resp_err_o      = err_q;
  assign busy_o          = (state_q != IDLE);

`ifdef GCD_SHARE_ARBITER_STATS_EN
  logic [15:0] stat_jobs_q, stat_jobs_d;
  logic [7:0]  stat_timeouts_q, stat_timeouts_d;

  // Both counters saturate instead of wrapping.
  always_comb begin
    stat_jobs_d     = stat_jobs_q;
    stat_timeouts_d = stat_timeouts_q;
    if (state_q == RESP) begin
      if (stat_jobs_q != 16'hFFFF) begin
        stat_jobs_d = stat_jobs_q + 16'd1;
      end
      if (err_q && stat_timeouts_q != 8'hFF) begin
        stat_timeouts_d = stat_timeouts_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stat_jobs_q     <= '0;
      stat_timeouts_q <= '0;
    end else begin
      stat_jobs_q     <= stat_jobs_d;
      stat_timeouts_q <= stat_timeouts_d;
    end
  end

  assign stat_jobs_o     = stat_jobs_q;
  assign stat_timeouts_o = stat_timeouts_q;
`endif

endmodule

// File: tb/tb_gcd_share_arbiter.sv
// Self-checking bench for gcd_share_arbiter: job-level reference model plus a behavioural gcd engine.
module tb_gcd_share_arbiter;

  localparam int DW = 16;
  localparam int NR = 2;
  localparam int TO = 16;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic [NR-1:0]     req_valid_i;
  logic [NR-1:0]     req_ready_o;
  logic [NR*DW-1:0]  req_operand_a_i;
  logic [NR*DW-1:0]  req_operand_b_i;
  logic [NR-1:0]     resp_valid_o;
  logic [DW-1:0]     resp_gcd_o;
  logic              resp_err_o;
  logic              busy_o;
  logic [DW-1:0]     gcd_operand_a_o;
  logic [DW-1:0]     gcd_operand_b_o;
  logic              gcd_enable_o;
  logic [DW-1:0]     gcd_result_i;
  logic              gcd_done_i;
`ifdef GCD_SHARE_ARBITER_STATS_EN
  logic [15:0]       stat_jobs_o;
  logic [7:0]        stat_timeouts_o;
`endif

  gcd_share_arbiter #(
    .DATA_WIDTH(DW),
    .NUM_REQ(NR),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_operand_a_i(req_operand_a_i),
    .req_operand_b_i(req_operand_b_i),
    .resp_valid_o(resp_valid_o),
    .resp_gcd_o(resp_gcd_o),
    .resp_err_o(resp_err_o),
    .busy_o(busy_o),
    .gcd_operand_a_o(gcd_operand_a_o),
    .gcd_operand_b_o(gcd_operand_b_o),
    .gcd_enable_o(gcd_enable_o),
    .gcd_result_i(gcd_result_i),
    .gcd_done_i(gcd_done_i)
`ifdef GCD_SHARE_ARBITER_STATS_EN
    ,
    .stat_jobs_o(stat_jobs_o),
    .stat_timeouts_o(stat_timeouts_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Engine behaviour: done after eng_lat enable cycles (negative = never).
  int eng_lat = -1;
  int en_cnt  = 0;

  // Reference model state (job level, not cycle-state level).
  bit            active     = 1'b0;
  bit            job_bypass = 1'b0;
  int            owner      = 0;
  int            grant_cyc  = 0;
  int            resp_cyc   = 0;
  int            rr         = 0;
  logic [DW-1:0] exp_gcd    = '0;
  bit            exp_err    = 1'b0;
  logic [DW-1:0] hold_a     = '0;
  logic [DW-1:0] hold_b     = '0;
  logic [DW-1:0] hold_gcd   = '0;
  int            resp_count = 0;
  int            jobs_since = 0;
  int            tos_since  = 0;

  // Observations recorded for the directed literal checks.
  int            last_grant [NR];
  logic [DW-1:0] gcd_by     [NR];
  int            last_owner    = -1;
  int            last_resp_cyc = 0;
  logic [DW-1:0] last_gcd      = '0;
  bit            last_err      = 1'b0;

  function automatic logic [DW-1:0] gcd_fn(input logic [DW-1:0] a_in, input logic [DW-1:0] b_in);
    logic [DW-1:0] a, b, t;
    a = a_in;
    b = b_in;
    while (b != '0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int winner(input logic [NR-1:0] v, input int p);
    for (int i = 0; i < NR; i++) begin
      if (v[(p + i) % NR]) return (p + i) % NR;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // Per-cycle compare of every DUT output against the job-level model.
  always @(negedge clk_i) begin
    logic [NR-1:0] exp_ready;
    logic [NR-1:0] exp_rv;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    bit            exp_en;
    bit            exp_busy;
    int            w;
    if (reset_i) begin
      active     = 1'b0;
      rr         = 0;
      hold_a     = '0;
      hold_b     = '0;
      hold_gcd   = '0;
      jobs_since = 0;
      tos_since  = 0;
    end else begin
      exp_ready = '0;
      exp_rv    = '0;
      exp_en    = 1'b0;
      exp_busy  = 1'b0;
      w         = -1;
      if (active && cyc > resp_cyc) active = 1'b0;
      if (active) begin
        exp_busy = 1'b1;
        exp_en   = !job_bypass && (cyc < resp_cyc);
        if (cyc == resp_cyc) exp_rv[owner] = 1'b1;
      end else begin
        w = winner(req_valid_i, rr);
        if (w >= 0) exp_ready[w] = 1'b1;
      end
      checkOutput("operand_a", gcd_operand_a_o, hold_a);
      checkOutput("operand_b", gcd_operand_b_o, hold_b);
      checkOutput("busy", busy_o, exp_busy);
      checkOutput("enable", gcd_enable_o, exp_en);
      checkOutput("resp_valid", resp_valid_o, exp_rv);
      checkOutput("req_ready", req_ready_o, exp_ready);
`ifdef GCD_SHARE_ARBITER_STATS_EN
      checkOutput("stat_jobs", stat_jobs_o, jobs_since);
      checkOutput("stat_timeouts", stat_timeouts_o, tos_since);
`endif
      if (active && cyc == resp_cyc) begin
        checkOutput("resp_gcd", resp_gcd_o, exp_gcd);
        checkOutput("resp_err", resp_err_o, exp_err);
        hold_gcd      = exp_gcd;
        last_owner    = owner;
        last_resp_cyc = cyc;
        last_gcd      = resp_gcd_o;
        last_err      = resp_err_o;
        gcd_by[owner] = resp_gcd_o;
        resp_count++;
        jobs_since++;
        if (exp_err) tos_since++;
      end else begin
        checkOutput("resp_gcd_hold", resp_gcd_o, hold_gcd);
      end
      if (!active && w >= 0) begin
        a          = req_operand_a_i[w*DW +: DW];
        b          = req_operand_b_i[w*DW +: DW];
        owner      = w;
        grant_cyc  = cyc;
        job_bypass = (a == '0) || (b == '0);
        if (job_bypass) begin
          exp_gcd  = a | b;
          exp_err  = 1'b0;
          resp_cyc = cyc + 1;
        end else if (eng_lat >= 2 && eng_lat <= TO + 1) begin
          exp_gcd  = gcd_fn(a, b);
          exp_err  = 1'b0;
          resp_cyc = cyc + eng_lat + 1;
        end else begin
          exp_gcd  = '0;
          exp_err  = 1'b1;
          resp_cyc = cyc + TO + 2;
        end
        hold_a        = a;
        hold_b        = b;
        rr            = (w + 1) % NR;
        active        = 1'b1;
        last_grant[w] = cyc;
      end
    end
  end

  // One clock: requesters drop valid after their handshake, engine model reacts to enable.
  task automatic tick();
    logic [NR-1:0] hs;
    @(negedge clk_i);
    hs = req_valid_i & req_ready_o;
    @(posedge clk_i);
    #1;
    req_valid_i = req_valid_i & ~hs;
    if (gcd_enable_o) en_cnt++;
    else en_cnt = 0;
    if (gcd_enable_o && eng_lat >= 0 && en_cnt == eng_lat) begin
      gcd_done_i   = 1'b1;
      gcd_result_i = gcd_fn(gcd_operand_a_o, gcd_operand_b_o);
    end else begin
      gcd_done_i   = 1'b0;
      gcd_result_i = 16'hBEEF;
    end
  endtask

  task automatic applyStimulus(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_operand_a_i[k*DW +: DW] = a;
    req_operand_b_i[k*DW +: DW] = b;
    req_valid_i[k]              = 1'b1;
  endtask

  task automatic waitResp(input int target);
    int budget;
    budget = 200;
    while (resp_count < target && budget > 0) begin
      tick();
      budget--;
    end
    if (resp_count < target) checkOutput("wait_resp", resp_count, target);
  endtask

  task automatic singleJob(input string name, input int k, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input int lat, input logic [DW-1:0] want_gcd, input bit want_err, input int want_lat);
    eng_lat = lat;
    applyStimulus(k, a, b);
    waitResp(resp_count + 1);
    checkOutput({name, "_owner"}, last_owner, k);
    checkOutput({name, "_gcd"}, last_gcd, want_gcd);
    checkOutput({name, "_err"}, last_err, want_err);
    checkOutput({name, "_latency"}, last_resp_cyc - last_grant[k], want_lat);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    reset_i         = 1'b1;
    req_valid_i     = '0;
    req_operand_a_i = '0;
    req_operand_b_i = '0;
    gcd_done_i      = 1'b0;
    gcd_result_i    = '0;
    repeat (3) tick();
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_enable", gcd_enable_o, 0);
    checkOutput("rst_resp_valid", resp_valid_o, 0);
    checkOutput("rst_resp_gcd", resp_gcd_o, 0);
    checkOutput("rst_operand_a", gcd_operand_a_o, 0);
    reset_i = 1'b0;
    tick();

    $display("[TB] single request");
    singleJob("single", 0, 16'd48, 16'd18, 4, 16'd6, 1'b0, 5);
    singleJob("req1", 1, 16'd100, 16'd75, 3, 16'd25, 1'b0, 4);

    $display("[TB] contention, pointer at req0");
    eng_lat = 5;
    n = resp_count;
    applyStimulus(0, 16'd35, 16'd14);
    applyStimulus(1, 16'd100, 16'd75);
    waitResp(n + 2);
    checkOutput("cont_gcd0", gcd_by[0], 7);
    checkOutput("cont_gcd1", gcd_by[1], 25);
    checkOutput("cont_back_to_back", last_grant[1] - last_grant[0], 7);

    $display("[TB] contention, pointer at req1");
    singleJob("ptr_setup", 0, 16'd21, 16'd6, 2, 16'd3, 1'b0, 3);
    eng_lat = 2;
    n = resp_count;
    applyStimulus(0, 16'd8, 16'd12);
    applyStimulus(1, 16'd9, 16'd27);
    waitResp(n + 2);
    checkOutput("ptr_req1_first", last_grant[1] < last_grant[0], 1);
    checkOutput("ptr_gcd0", gcd_by[0], 4);
    checkOutput("ptr_gcd1", gcd_by[1], 9);

    $display("[TB] zero operands");
    singleJob("zero_a", 0, 16'd0, 16'd9, 3, 16'd9, 1'b0, 1);
    singleJob("zero_b", 1, 16'd12, 16'd0, 3, 16'd12, 1'b0, 1);
    singleJob("zero_ab", 0, 16'd0, 16'd0, 3, 16'd0, 1'b0, 1);

    $display("[TB] timeout");
    singleJob("timeout", 1, 16'd15, 16'd10, -1, 16'd0, 1'b1, TO + 2);
    singleJob("after_to", 0, 16'd15, 16'd10, 2, 16'd5, 1'b0, 3);
    singleJob("done_last", 1, 16'd64, 16'd48, TO + 1, 16'd16, 1'b0, TO + 2);
    singleJob("done_late", 0, 16'd64, 16'd48, TO + 2, 16'd0, 1'b1, TO + 2);

    $display("[TB] reset during WAIT");
    eng_lat = -1;
    applyStimulus(0, 16'd30, 16'd20);
    repeat (6) tick();
    checkOutput("pre_rst_busy", busy_o, 1);
    n = resp_count;
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    checkOutput("mid_rst_busy", busy_o, 0);
    checkOutput("mid_rst_enable", gcd_enable_o, 0);
    checkOutput("mid_rst_resp_valid", resp_valid_o, 0);
    checkOutput("mid_rst_operand_a", gcd_operand_a_o, 0);
    checkOutput("mid_rst_resp_gcd", resp_gcd_o, 0);
    repeat (20) tick();
    checkOutput("mid_rst_no_resp", resp_count, n);
    eng_lat = 3;
    applyStimulus(0, 16'd44, 16'd33);
    applyStimulus(1, 16'd50, 16'd20);
    waitResp(n + 2);
    checkOutput("rst_ptr_req0_first", last_grant[0] < last_grant[1], 1);
    checkOutput("rst_gcd0", gcd_by[0], 11);
    checkOutput("rst_gcd1", gcd_by[1], 10);

`ifdef GCD_SHARE_ARBITER_STATS_EN
    $display("[TB] statistics");
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    tick();
    singleJob("st1", 0, 16'd6, 16'd4, 2, 16'd2, 1'b0, 3);
    singleJob("st2", 1, 16'd9, 16'd6, 2, 16'd3, 1'b0, 3);
    singleJob("st3", 0, 16'd0, 16'd5, 2, 16'd5, 1'b0, 1);
    singleJob("st4", 1, 16'd7, 16'd3, -1, 16'd0, 1'b1, TO + 2);
    checkOutput("stat_jobs_total", stat_jobs_o, 4);
    checkOutput("stat_timeouts_total", stat_timeouts_o, 1);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    checkOutput("stat_jobs_cleared", stat_jobs_o, 0);
    checkOutput("stat_timeouts_cleared", stat_timeouts_o, 0);
`endif

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gcd_share_arbiter.md
Name: gcd_share_arbiter

Overview:
- Shares the single gcd_top engine between NUM_REQ requesters, e.g. the SPI register file and on-chip test logic.
- Round-robin arbitration with valid/ready request handshake; operands are latched at grant.
- Sequences the engine: drives enable, waits for done, supervises with a timeout.
- Returns the result to the granted requester only. Sits between requesters and gcd_top inside tt_um_sobel_gcd_unal.

Parameters:
- DATA_WIDTH, 16, operand/result width; matches gcd_top.
- NUM_REQ, 2, number of requesters (2..4).
- TIMEOUT_CYCLES, 1024, maximum WAIT cycles before abort.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- req_valid_i  in  NUM_REQ  per-requester request.
- req_ready_o  out  NUM_REQ  one-hot grant/accept pulse.
- req_operand_a_i  in  NUM_REQ*DATA_WIDTH  operand A, requester k at slice [k*DATA_WIDTH +: DATA_WIDTH].
- req_operand_b_i  in  NUM_REQ*DATA_WIDTH  operand B, same packing.
- resp_valid_o  out  NUM_REQ  one-hot, 1-cycle result strobe.
- resp_gcd_o  out  DATA_WIDTH  result; valid only while a resp_valid_o bit is high.
- resp_err_o  out  1  timeout flag, qualified by resp_valid_o.
- busy_o  out  1  high in any state except IDLE.
- gcd_operand_a_o  out  DATA_WIDTH  to engine.
- gcd_operand_b_o  out  DATA_WIDTH  to engine.
- gcd_enable_o  out  1  engine run enable.
- gcd_result_i  in  DATA_WIDTH  engine result.
- gcd_done_i  in  1  engine completion.

Behaviour:
- Clocking and reset:
  - All state updates on posedge clk_i.
  - reset_i is sampled synchronously and overrides everything, including an operation in flight. No response is produced for an aborted job.
  - Reset values: all outputs 0; round-robin pointer = 0; timeout counter = 0; FSM = IDLE.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Search req_valid_i starting at the pointer, wrapping modulo NUM_REQ.
  - First set bit k wins: req_ready_o[k]=1 combinationally for that cycle. The handshake completes on valid&ready.
  - Latch operands into gcd_operand_a/b_o and record owner=k. Pointer becomes (k+1) mod NUM_REQ.
  - If either latched operand is 0: bypass the engine; result = a|b (gcd(0,b)=b, gcd(a,0)=a, gcd(0,0)=0); go to RESP.
  - Otherwise go to ISSUE.
  - No valid requests: stay in IDLE; pointer unchanged.
- ISSUE:
  - gcd_enable_o=1; clear the timeout counter; go to WAIT.
- WAIT:
  - gcd_enable_o held at 1; counter increments each cycle.
  - gcd_done_i=1: latch gcd_result_i, err=0, go to RESP.
  - Counter reaches TIMEOUT_CYCLES-1 without done: result=0, err=1, go to RESP.
  - done and timeout in the same cycle: done wins (err=0).
- RESP:
  - gcd_enable_o=0.
  - resp_valid_o[owner]=1 for exactly one cycle, with resp_gcd_o and resp_err_o.
  - Go to IDLE. A new grant is possible on the next cycle.
- Latency:
  - Non-zero operands: grant at T, enable from T+1, done seen at D, response at D+1.
  - Zero operand: response at T+1.
- Requests are ignored outside IDLE; ready stays 0 and requesters hold valid.
- Operand outputs are stable from the grant until the next grant.
- resp_gcd_o is held after RESP but is only meaningful with resp_valid_o.

Optional Feature:
- Macro: GCD_SHARE_ARBITER_STATS_EN.
- When defined:
  - Adds output stat_jobs_o[15:0]: count of completed responses, saturating at 0xFFFF.
  - Adds output stat_timeouts_o[7:0]: count of err responses, saturating at 0xFF.
  - Both counters clear on reset_i.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single request: req0 with a=48, b=18 -> ready[0] at T; enable high from T+1 until the RESP cycle; model done with result 6 -> resp_valid[0] one cycle, gcd=6, err=0.
- Contention: both valid with pointer=0 -> req0 served first (a=35, b=14 -> 7). Then req1 served (a=100, b=75 -> 25) with no idle gap beyond the RESP->IDLE cycle. Next contention grants req1 first only if the pointer points at it.
- Zero operands: a=0, b=9 -> gcd 9; a=12, b=0 -> 12; a=0, b=0 -> 0. Each responds at T+1 with gcd_enable_o never asserted.
- Timeout: engine never asserts done with TIMEOUT_CYCLES=16 -> resp_err_o=1, gcd=0, enable drops; the next request is served normally. Also assert done on the final counter cycle -> err=0.
- Reset mid-WAIT: assert reset_i during WAIT -> next cycle all outputs 0, FSM IDLE, no resp_valid_o, pointer 0.
- Stats (with GCD_SHARE_ARBITER_STATS_EN): 3 good jobs plus 1 timeout -> stat_jobs_o=4, stat_timeouts_o=1; reset clears both.
